// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state and owner encodings for the dmem arbiter
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ACCESS = S_ACCESS,
    ST_DONE   = S_DONE
  } state_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == P_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// rtl/dmem_arb_rr_pick2.sv - two-way round-robin pick
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       both
);

  // A tie goes to the port not served last; otherwise the lone requester wins.
  assign both = &req;
  assign pick = both ? ~last : req[1];

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - two-port round-robin arbiter in front of the single-port dmem
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_amp,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_amp,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          ram_we,
  output logic [3:0]    ram_amp,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wd,
  input  logic [DW-1:0] ram_rd,
  output logic [1:0]    grant,
  output logic [CW-1:0] conflict_cnt
);

  state_t        state_q, state_d;
  logic          owner_q;
  logic          last_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;
  logic [CW-1:0] cnt_q;
  logic          pick, both;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .pick (pick),
    .both (both)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= P_CPU;
      last_q     <= P_DBG;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (m0_req | m1_req) owner_q <= pick;
          if (both && (cnt_q != {CW{1'b1}})) cnt_q <= cnt_q + CW'(1);
        end
        ST_ACCESS: begin
          if (owner_q == P_DBG) m1_rdata_q <= ram_rd;
          else                  m0_rdata_q <= ram_rd;
          last_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (m0_req | m1_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ram_* are purely state-decoded so an async reset kills a write before the edge.
  always_comb begin
    ram_we   = 1'b0;
    ram_amp  = '0;
    ram_addr = '0;
    ram_wd   = '0;
    grant    = 2'b00;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        grant = owner_onehot(owner_q);
        if (owner_q == P_DBG) begin
          ram_we   = m1_we;
          ram_amp  = m1_amp;
          ram_addr = m1_addr;
          ram_wd   = m1_wdata;
        end else begin
          ram_we   = m0_we;
          ram_amp  = m0_amp;
          ram_addr = m0_addr;
          ram_wd   = m0_wdata;
        end
      end
      ST_DONE: begin
        grant  = owner_onehot(owner_q);
        m0_ack = (owner_q == P_CPU);
        m1_ack = (owner_q == P_DBG);
      end
      default: ;
    endcase
  end

  assign m0_stall     = m0_req & ~m0_ack;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - directed self-checking bench for dmem_arb
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_amp, m1_amp;
  logic [6:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, ram_rd;

  logic [31:0] m0_rdata, m1_rdata, ram_wd;
  logic        m0_ack, m1_ack, m0_stall, ram_we;
  logic [3:0]  ram_amp;
  logic [6:0]  ram_addr;
  logic [1:0]  grant;
  logic [15:0] conflict_cnt;

  logic [31:0] s_m0_rdata, s_m1_rdata, s_ram_wd;
  logic        s_m0_ack, s_m1_ack, s_m0_stall, s_ram_we;
  logic [3:0]  s_ram_amp;
  logic [6:0]  s_ram_addr;
  logic [1:0]  s_grant;
  logic [1:0]  s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arb #(.AW(7), .DW(32), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_we(ram_we), .ram_amp(ram_amp), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .grant(grant), .conflict_cnt(conflict_cnt)
  );

  dmem_arb #(.AW(7), .DW(32), .CW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(s_m0_rdata), .m0_ack(s_m0_ack), .m0_stall(s_m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(s_m1_rdata), .m1_ack(s_m1_ack),
    .ram_we(s_ram_we), .ram_amp(s_ram_amp), .ram_addr(s_ram_addr), .ram_wd(s_ram_wd),
    .ram_rd(ram_rd), .grant(s_grant), .conflict_cnt(s_conflict_cnt)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [3:0]  amp;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_amp = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_amp = 0; m1_addr = 0; m1_wdata = 0;
    ram_rd = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
    chk({tag, "_r0"}, m0_rdata, 32'd0);
    chk({tag, "_r1"}, m1_rdata, 32'd0);
    chk({tag, "_cnt"}, 32'(conflict_cnt), 32'd0);
    chk({tag, "_ram"}, {ram_we, ram_amp, 20'd0, ram_addr}, 32'd0);
    chk({tag, "_wd"}, ram_wd, 32'd0);
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge after DONE.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    ram_rd = v.rd;
    if (v.port) begin
      m1_req = 1; m1_we = v.we; m1_amp = v.amp; m1_addr = v.addr; m1_wdata = v.wd;
    end else begin
      m0_req = 1; m0_we = v.we; m0_amp = v.amp; m0_addr = v.addr; m0_wdata = v.wd;
    end
    #1;
    chk({t, "_idle_ram_we"}, 32'(ram_we), 32'd0);
    chk({t, "_idle_stall"}, 32'(m0_stall), 32'(!v.port));
    @(negedge clk);
    chk({t, "_acc_addr"}, 32'(ram_addr), 32'(v.addr));
    chk({t, "_acc_we"}, 32'(ram_we), 32'(v.we));
    chk({t, "_acc_amp"}, 32'(ram_amp), 32'(v.amp));
    chk({t, "_acc_wd"}, ram_wd, v.wd);
    chk({t, "_acc_grant"}, 32'(grant), v.port ? 32'd2 : 32'd1);
    chk({t, "_acc_acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
    chk({t, "_acc_stall"}, 32'(m0_stall), 32'(!v.port));
    @(negedge clk);
    chk({t, "_done_acks"}, {30'd0, m1_ack, m0_ack}, v.port ? 32'd2 : 32'd1);
    chk({t, "_done_grant"}, 32'(grant), v.port ? 32'd2 : 32'd1);
    chk({t, "_done_r0"}, m0_rdata, v.exp_r0);
    chk({t, "_done_r1"}, m1_rdata, v.exp_r1);
    chk({t, "_done_ram"}, {ram_we, ram_amp, 20'd0, ram_addr}, 32'd0);
    chk({t, "_done_stall"}, 32'(m0_stall), 32'd0);
    idle_inputs();
    @(negedge clk);
    chk({t, "_after_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  vec_t vecs[5];
  int   n0, n1, expect_port;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'hF, 7'h05, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 7'h10, 32'h12345678, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 7'h7F, 32'h0,        32'h0BADF00D, 32'hDEADBEEF, 32'h0BADF00D};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 7'h00, 32'hFFFFFFFF, 32'h11112222, 32'h11112222, 32'h0BADF00D};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 7'h2A, 32'h0,        32'h55AA55AA, 32'h55AA55AA, 32'h0BADF00D};

    idle_inputs();
    rst = 1;
    #1;
    chk_reset_state("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_reset_state("rst0_rel");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    chk("single_cnt", 32'(conflict_cnt), 32'd0);

    // Tie straight after reset: port 0 first, then port 1.
    do_reset();
    m0_req = 1; m0_addr = 7'h01; m1_req = 1; m1_addr = 7'h02; ram_rd = 32'hCAFE0001;
    @(negedge clk);
    chk("tie_grant0", 32'(grant), 32'd1);
    chk("tie_addr0", 32'(ram_addr), 32'h01);
    chk("tie_cnt", 32'(conflict_cnt), 32'd1);
    @(negedge clk);
    chk("tie_ack0", {30'd0, m1_ack, m0_ack}, 32'd1);
    chk("tie_r0", m0_rdata, 32'hCAFE0001);
    m0_req = 0; ram_rd = 32'hCAFE0002;
    @(negedge clk);
    chk("tie_idle_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("tie_grant1", 32'(grant), 32'd2);
    chk("tie_addr1", 32'(ram_addr), 32'h02);
    @(negedge clk);
    chk("tie_ack1", {30'd0, m1_ack, m0_ack}, 32'd2);
    chk("tie_r1", m1_rdata, 32'hCAFE0002);
    chk("tie_cnt_final", 32'(conflict_cnt), 32'd1);
    idle_inputs();
    @(negedge clk);

    // Continuous contention: 12 transactions, strictly alternating.
    do_reset();
    m0_req = 1; m1_req = 1;
    n0 = 0; n1 = 0; expect_port = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        chk($sformatf("cont_ack%0d", n0 + n1), {30'd0, m1_ack, m0_ack},
            expect_port ? 32'd2 : 32'd1);
        if (m0_ack) n0++;
        if (m1_ack) n1++;
        expect_port = 1 - expect_port;
      end
    end
    chk("cont_n0", 32'(n0), 32'd6);
    chk("cont_n1", 32'(n1), 32'd6);
    chk("cont_cnt", 32'(conflict_cnt), 32'd12);
    chk("sat_cnt", 32'(s_conflict_cnt), 32'd3);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);

    // Async reset during the ACCESS cycle of a write.
    do_reset();
    m0_req = 1; m0_we = 1; m0_amp = 4'hF; m0_addr = 7'h33; m0_wdata = 32'h0F0F0F0F;
    ram_rd = 32'h77777777;
    @(negedge clk);
    chk("ar_we_before", 32'(ram_we), 32'd1);
    rst = 1;
    #1;
    chk("ar_we_dropped", 32'(ram_we), 32'd0);
    chk("ar_grant", 32'(grant), 32'd0);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar_noack%0d", k), {30'd0, m1_ack, m0_ack}, 32'd0);
    end
    rst = 0;
    @(negedge clk);
    chk_reset_state("ar_rel");
    run_vec(vecs[0], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
